// File: rtl/dose_log_uart_tx_if.sv
// Event bus from the dose logger into the dose-log UART transmitter.
// The logger side is the master; the transmitter samples it as slave.
interface dose_log_uart_tx_if;
    logic       ev_valid;
    logic [7:0] ev_time;
    logic [3:0] ev_idx;

    modport master (output ev_valid, ev_time, ev_idx);
    modport slave  (input  ev_valid, ev_time, ev_idx);
endinterface

// File: rtl/dose_log_uart_tx.sv
// Buffers dose-log events and sends each as a framed UART packet A5, time, idx[, checksum].
// Define DOSE_TX_CHECKSUM_EN to append the XOR checksum byte (4-byte packets instead of 3).
module dose_log_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dose_log_uart_tx_if.slave             ev,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
`ifdef DOSE_TX_CHECKSUM_EN
    localparam logic [1:0]    LAST_BYTE  = 2'd3;
`else
    localparam logic [1:0]    LAST_BYTE  = 2'd2;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_q, clk_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [11:0]   pkt_q;
    logic [7:0]    cur_byte;
    logic          tx_d;

    // ---------------- event FIFO ----------------
    logic [11:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic        full, empty, push, pop, drop;

    assign level      = wr_ptr - rd_ptr;
    assign fifo_level = level;
    assign full       = (level == LEVEL_FULL);
    assign empty      = (level == '0);
    assign pop        = (state_q == S_LOAD);
    assign push       = ev.ev_valid && (!full || pop);
    assign drop       = ev.ev_valid && full && !pop;

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {ev.ev_time, ev.ev_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // ---------------- packet byte select ----------------
    always_comb begin
        cur_byte = 8'hA5;
        case (byte_q)
            2'd1:    cur_byte = pkt_q[11:4];
            2'd2:    cur_byte = {4'h0, pkt_q[3:0]};
`ifdef DOSE_TX_CHECKSUM_EN
            2'd3:    cur_byte = 8'hA5 ^ pkt_q[11:4] ^ {4'h0, pkt_q[3:0]};
`endif
            default: cur_byte = 8'hA5;
        endcase
    end

    // ---------------- serializer FSM ----------------
    // NOTE: every variable gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: if (!empty) state_d = S_LOAD;
            S_LOAD: begin
                clk_d   = '0;
                bit_d   = '0;
                byte_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (clk_q == BIT_LAST) begin
                    clk_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else clk_d = clk_q + 1'b1;
            end
            S_DATA: begin
                if (clk_q == BIT_LAST) begin
                    clk_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else clk_d = clk_q + 1'b1;
            end
            S_STOP: begin
                if (clk_q == BIT_LAST) begin
                    clk_d = '0;
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = S_START;
                    end else if (!empty) state_d = S_LOAD;
                    else                 state_d = S_IDLE;
                end else clk_d = clk_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered line: byte_q and pkt_q never change on entry to DATA, so cur_byte is already right.
        tx_d = 1'b1;
        if (state_d == S_START)     tx_d = 1'b0;
        else if (state_d == S_DATA) tx_d = cur_byte[bit_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            clk_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            pkt_q   <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx      <= tx_d;
            if (state_q == S_LOAD) pkt_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dose_log_uart_tx.sv
// Bench for dose_log_uart_tx: a queue-of-line-samples model checked every cycle plus literal scenarios.
// Follows DOSE_TX_CHECKSUM_EN like the design (3- or 4-byte packets).
module tb_dose_log_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
`ifdef DOSE_TX_CHECKSUM_EN
    localparam int NB      = 4;
    localparam int EXP_DUR = 640;
`else
    localparam int NB      = 3;
    localparam int EXP_DUR = 480;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tx, busy, overflow;
    logic [3:0] fifo_level;

    dose_log_uart_tx_if ev_if ();

    dose_log_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev         (ev_if),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_q: accepted events; m_w: tx level for the current and following cycles while busy.
    logic [11:0] m_q [$];
    bit          m_w [$];
    bit          m_load;
    bit          m_ovf;
    int          m_accepted = 0;

    function automatic void append_packet(input logic [11:0] e);
        logic [7:0] b [4];
        b[0] = 8'hA5;
        b[1] = e[11:4];
        b[2] = {4'h0, e[3:0]};
        b[3] = b[0] ^ b[1] ^ b[2];
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CPB; c++) m_w.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int c = 0; c < CPB; c++) m_w.push_back(b[k][i]);
            for (int c = 0; c < CPB; c++) m_w.push_back(1'b1);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_step
        int          had;
        bit          pop, full;
        logic [11:0] e;
        if (!rst_n) begin
            m_q.delete();
            m_w.delete();
            m_load = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            had  = m_q.size();
            full = (had == DEPTH);
            pop  = m_load;
            if (m_w.size() != 0) void'(m_w.pop_front());
            if (pop) begin
                e = m_q.pop_front();
                append_packet(e);
            end
            m_load = (m_w.size() == 0) && (had > 0);
            if (m_load) m_w.push_back(1'b1);
            if (ev_if.ev_valid && (!full || pop)) begin
                m_q.push_back({ev_if.ev_time, ev_if.ev_idx});
                m_accepted++;
            end
            if (ev_if.ev_valid && full && !pop) m_ovf = 1'b1;
            else if (clr_ovf)                  m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("tx",       tx,         (m_w.size() != 0) ? m_w[0] : 1'b1);
            check("busy",     busy,       m_w.size() != 0);
            check("level",    fifo_level, m_q.size());
            check("overflow", overflow,   m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic ev_cycle(input bit v, input logic [7:0] t, input logic [3:0] i);
        ev_if.ev_valid = v;
        ev_if.ev_time  = t;
        ev_if.ev_idx   = i;
        @(negedge clk);
        ev_if.ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while ((busy || fifo_level != 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, k < limit, 1'b1);
    endtask

    initial begin
        int   lat, busy_cnt, peak, acc0, lows, burst;
        logic line [0:39];
        logic [7:0] rb;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h05; exp_b[3] = 8'h9C;

        ev_if.ev_valid = 1'b0;
        ev_if.ev_time  = '0;
        ev_if.ev_idx   = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_level", fifo_level, 4'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single event: latency, byte content, packet duration.
        ev_cycle(1'b1, 8'h3C, 4'h5);
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency", lat, 2);
        busy_cnt = 0;
        for (int t = 0; t < NB * 10 * CPB; t++) begin
            if (t % CPB == CPB / 2) line[t / CPB] = tx;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < 8; i++) rb[i] = line[k * 10 + 1 + i];
            check("start_bit", line[k * 10], 1'b0);
            check("data_byte", rb, exp_b[k]);
            check("stop_bit", line[k * 10 + 9], 1'b1);
        end
        check("busy_dur", busy_cnt, EXP_DUR);
        check("busy_end", busy, 1'b0);
        check("tx_end", tx, 1'b1);

        // Three back-to-back events.
        wait_idle(2000, "idle_to_s2");
        acc0 = m_accepted;
        peak = 0; busy_cnt = 0;
        ev_cycle(1'b1, 8'h10, 4'h1);
        if (fifo_level > peak) peak = fifo_level; if (busy) busy_cnt++;
        ev_cycle(1'b1, 8'h20, 4'h2);
        if (fifo_level > peak) peak = fifo_level; if (busy) busy_cnt++;
        ev_cycle(1'b1, 8'h30, 4'h3);
        for (int k = 0; k < 4000 && (busy || fifo_level != 0); k++) begin
            if (fifo_level > peak) peak = fifo_level;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("b2b_peak", peak, 2);
        check("b2b_accepted", m_accepted - acc0, 3);
        check("b2b_busy_cycles", busy_cnt, 3 * (EXP_DUR + 1));

        // Overflow: ten events in ten cycles from idle.
        wait_idle(2000, "idle_to_s3");
        acc0 = m_accepted;
        for (int k = 0; k < 10; k++) ev_cycle(1'b1, 8'($urandom), 4'($urandom));
        check("ovf_set", overflow, 1'b1);
        check("ovf_level", fifo_level, 4'd8);
        check("ovf_accepted", m_accepted - acc0, 9);
        wait_idle(20000, "drain_s3");
        check("ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clear", overflow, 1'b0);

        // Full FIFO with an event arriving during LOAD.
        acc0 = m_accepted;
        for (int k = 0; k < 9; k++) ev_cycle(1'b1, 8'($urandom), 4'($urandom));
        check("full_level", fifo_level, 4'd8);
        lat = 0;
        while (!(m_load && m_q.size() == DEPTH) && lat < 2 * EXP_DUR) begin
            @(negedge clk);
            lat++;
        end
        check("load_found", lat < 2 * EXP_DUR, 1'b1);
        ev_cycle(1'b1, 8'hE7, 4'hB);
        check("simul_ovf", overflow, 1'b0);
        check("simul_level", fifo_level, 4'd8);
        check("simul_accepted", m_accepted - acc0, 10);
        wait_idle(20000, "drain_s4");

        // Reset during DATA of the second byte.
        ev_cycle(1'b1, 8'h5A, 4'h9);
        ev_cycle(1'b1, 8'hC3, 4'h2);
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        repeat (10 * CPB + 4 * CPB) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_level", fifo_level, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0; busy_cnt = 0;
        for (int k = 0; k < 2 * EXP_DUR; k++) begin
            @(negedge clk);
            if (!tx) lows++;
            if (busy) busy_cnt++;
        end
        check("post_rst_tx_lows", lows, 0);
        check("post_rst_busy", busy_cnt, 0);

        // Randomized traffic with occasional bursts and overflow clears.
        burst = 0;
        for (int c = 0; c < 8000; c++) begin
            if (burst == 0 && $urandom_range(0, 999) == 0) burst = $urandom_range(2, 12);
            ev_if.ev_valid = (burst > 0) || ($urandom_range(0, 249) == 0);
            if (burst > 0) burst--;
            ev_if.ev_time = 8'($urandom);
            ev_if.ev_idx  = 4'($urandom);
            clr_ovf       = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        ev_if.ev_valid = 1'b0;
        clr_ovf = 1'b0;
        wait_idle(12000, "drain_random");
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
